// File: rtl/screen_pkg.sv
// Shared definitions for the screen blitter: default geometry, FSM states and
// the raster coordinate-to-offset helper.
package screen_pkg;

    localparam int SCR_W_DEF      = 112;
    localparam int SCR_H_DEF      = 112;
    localparam int COLOR_BITS_DEF = 3;
    localparam int ADDR_BITS_DEF  = 14;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ISSUE   = 3'd1,
        WAIT    = 3'd2,
        PLOT    = 3'd3,
        ADVANCE = 3'd4,
        DONE    = 3'd5
    } blit_state_t;

    // Linear framebuffer offset of pixel (x, y) in a row-major frame of width w.
    function automatic logic [31:0] pixel_offset(input logic [31:0] x,
                                                 input logic [31:0] y,
                                                 input logic [31:0] w);
        return x + y * w;
    endfunction

endpackage

// File: rtl/screen_blit_pixel_scan_counter.sv
// Raster x/y counter: clears to (0,0), steps left-to-right then top-to-bottom,
// and flags the last pixel of the frame.
module pixel_scan_counter #(
    parameter int SCR_W  = 4,
    parameter int SCR_H  = 3,
    parameter int X_BITS = 7,
    parameter int Y_BITS = 7
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              step,
    output logic [X_BITS-1:0] x,
    output logic [Y_BITS-1:0] y,
    output logic              last
);

    logic row_end;

    assign row_end = (x == X_BITS'(SCR_W - 1));
    assign last    = row_end && (y == Y_BITS'(SCR_H - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x <= '0;
            y <= '0;
        end else if (clear) begin
            x <= '0;
            y <= '0;
        end else if (step) begin
            if (row_end) begin
                x <= '0;
                // Hold at the final row so coordinates never leave the frame.
                if (!last)
                    y <= y + 1'b1;
            end else begin
                x <= x + 1'b1;
            end
        end
    end

endmodule

// File: rtl/screen_blit.sv
// Framebuffer-to-VGA blitter: reads one pixel per raster position, strobes plot
// unless transparent, then hands off via the continuation signals.
module screen_blit
    import screen_pkg::*;
#(
    parameter int SCR_W       = SCR_W_DEF,
    parameter int SCR_H       = SCR_W_DEF,
    parameter int X_BITS      = 7,
    parameter int Y_BITS      = 7,
    parameter int COLOR_BITS  = COLOR_BITS_DEF,
    parameter int ADDR_BITS   = ADDR_BITS_DEF,
    parameter int MEM_LATENCY = 1
) (
    input  logic                  Clck,
    input  logic                  Reset,
    input  logic                  in_cont_signal,
    input  logic                  next_fin_signal,
    input  logic [ADDR_BITS-1:0]  base_addr,
    input  logic                  skip_en,
    input  logic [COLOR_BITS-1:0] skip_color,
    output logic [ADDR_BITS-1:0]  read_addr,
    input  logic [COLOR_BITS-1:0] read_data,
    output logic [X_BITS-1:0]     x_co,
    output logic [Y_BITS-1:0]     y_co,
    output logic [COLOR_BITS-1:0] colour,
    output logic                  plot,
    output logic                  busy,
    output logic                  out_cont_signal,
    output logic [2:0]            dbg_state
);

    blit_state_t           state, next_state;
    logic                  scan_clear, scan_step, scan_last;
    logic [1:0]            lat_cnt;
    logic [ADDR_BITS-1:0]  base_l;
    logic                  skip_en_l;
    logic [COLOR_BITS-1:0] skip_color_l;

    assign dbg_state = state;

    pixel_scan_counter #(
        .SCR_W  (SCR_W),
        .SCR_H  (SCR_H),
        .X_BITS (X_BITS),
        .Y_BITS (Y_BITS)
    ) u_scan (
        .clk   (Clck),
        .rst_n (Reset),
        .clear (scan_clear),
        .step  (scan_step),
        .x     (x_co),
        .y     (y_co),
        .last  (scan_last)
    );

    always_ff @(posedge Clck or negedge Reset) begin
        if (!Reset)
            state <= IDLE;
        else
            state <= next_state;
    end

    always_comb begin
        next_state = state;
        scan_clear = 1'b0;
        scan_step  = 1'b0;
        case (state)
            IDLE: begin
                if (in_cont_signal) begin
                    next_state = ISSUE;
                    scan_clear = 1'b1;
                end
            end
            ISSUE:   next_state = WAIT;
            WAIT:    if (lat_cnt == 2'd0) next_state = PLOT;
            PLOT:    next_state = ADVANCE;
            ADVANCE: begin
                if (scan_last) begin
                    next_state = DONE;
                end else begin
                    next_state = ISSUE;
                    scan_step  = 1'b1;
                end
            end
            DONE:    if (next_fin_signal) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Datapath and registered outputs; busy/out_cont follow the next state so
    // they change on the same edge as the state itself.
    always_ff @(posedge Clck or negedge Reset) begin
        if (!Reset) begin
            read_addr       <= '0;
            colour          <= '0;
            plot            <= 1'b0;
            busy            <= 1'b0;
            out_cont_signal <= 1'b0;
            lat_cnt         <= '0;
            base_l          <= '0;
            skip_en_l       <= 1'b0;
            skip_color_l    <= '0;
        end else begin
            busy            <= (next_state != IDLE);
            out_cont_signal <= (next_state == DONE);
            plot            <= 1'b0;
            case (state)
                IDLE: begin
                    if (in_cont_signal) begin
                        base_l       <= base_addr;
                        skip_en_l    <= skip_en;
                        skip_color_l <= skip_color;
                    end
                end
                ISSUE: begin
                    read_addr <= ADDR_BITS'(32'(base_l) +
                                 pixel_offset(32'(x_co), 32'(y_co), 32'(SCR_W)));
                    lat_cnt   <= 2'(MEM_LATENCY - 1);
                end
                WAIT: begin
                    if (lat_cnt == 2'd0) begin
                        colour <= read_data;
                        plot   <= !(skip_en_l && (read_data == skip_color_l));
                    end else begin
                        lat_cnt <= lat_cnt - 2'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_screen_blit.sv
// Directed bench for screen_blit on a 4x3 frame, with a latency-1 and a
// latency-3 instance backed by memories holding mem[i] = i mod 8.
module tb_screen_blit;

    logic        Clck;
    logic        Reset;
    logic [13:0] base_addr;
    logic        skip_en;
    logic [2:0]  skip_color;

    logic        in_cont, next_fin;
    logic [13:0] ra;
    logic [2:0]  rd;
    logic [6:0]  xc, yc;
    logic [2:0]  col;
    logic        plot, busy, oc;
    logic [2:0]  st;

    logic        in_cont3, next_fin3;
    logic [13:0] ra3, a1, a2;
    logic [2:0]  rd3;
    logic [6:0]  xc3, yc3;
    logic [2:0]  col3;
    logic        plot3, busy3, oc3;
    logic [2:0]  st3;

    int checks = 0;
    int errors = 0;

    screen_blit #(.SCR_W(4), .SCR_H(3), .X_BITS(7), .Y_BITS(7), .COLOR_BITS(3),
                  .ADDR_BITS(14), .MEM_LATENCY(1)) dut (
        .Clck(Clck), .Reset(Reset), .in_cont_signal(in_cont), .next_fin_signal(next_fin),
        .base_addr(base_addr), .skip_en(skip_en), .skip_color(skip_color),
        .read_addr(ra), .read_data(rd), .x_co(xc), .y_co(yc), .colour(col),
        .plot(plot), .busy(busy), .out_cont_signal(oc), .dbg_state(st));

    screen_blit #(.SCR_W(4), .SCR_H(3), .X_BITS(7), .Y_BITS(7), .COLOR_BITS(3),
                  .ADDR_BITS(14), .MEM_LATENCY(3)) dut3 (
        .Clck(Clck), .Reset(Reset), .in_cont_signal(in_cont3), .next_fin_signal(next_fin3),
        .base_addr(base_addr), .skip_en(skip_en), .skip_color(skip_color),
        .read_addr(ra3), .read_data(rd3), .x_co(xc3), .y_co(yc3), .colour(col3),
        .plot(plot3), .busy(busy3), .out_cont_signal(oc3), .dbg_state(st3));

    // Memory contents are i mod 8: latency 1 is a combinational read, latency 3
    // adds two address register stages in front of it.
    assign rd = ra[2:0];
    always @(posedge Clck) begin
        a1 <= ra3;
        a2 <= a1;
    end
    assign rd3 = a2[2:0];

    initial begin
        Clck = 1'b0;
        forever #5 Clck = ~Clck;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Starts a frame, scrambles the sampled inputs, and checks every cycle up to DONE.
    task automatic run_frame(input logic [13:0] b, input logic se, input logic [2:0] sc);
        int          p;
        logic [13:0] addr;
        logic [2:0]  c;
        logic        exp_plot;
        base_addr  = b;
        skip_en    = se;
        skip_color = sc;
        in_cont    = 1'b1;
        @(posedge Clck); #1;
        in_cont    = 1'b0;
        base_addr  = 14'($urandom_range(0, 16383));
        skip_en    = 1'($urandom_range(0, 1));
        skip_color = 3'($urandom_range(0, 7));
        for (int k = 1; k <= 48; k++) begin
            @(posedge Clck); #1;
            p    = (k - 1) / 4;
            addr = b + 14'(p);
            c    = addr[2:0];
            exp_plot = 1'b0;
            if (k % 4 == 1)
                check("read_addr", ra, addr);
            if (k % 4 == 2) begin
                exp_plot = !(se && (c == sc));
                check("x_co", xc, p % 4);
                check("y_co", yc, p / 4);
                check("colour", col, c);
            end
            check("plot", plot, exp_plot);
            check("out_cont", oc, k == 48);
            check("busy", busy, 1);
        end
    endtask

    task automatic finish_frame(input int hold);
        next_fin = 1'b0;
        for (int i = 0; i < hold; i++) begin
            @(posedge Clck); #1;
            check("out_cont_hold", oc, 1);
            check("busy_hold", busy, 1);
        end
        next_fin = 1'b1;
        @(posedge Clck); #1;
        next_fin = 1'b0;
        check("out_cont_clear", oc, 0);
        check("busy_clear", busy, 0);
        check("state_idle", st, 0);
    endtask

    initial begin
        int plots;
        Reset      = 1'b0;
        in_cont    = 1'b0;
        next_fin   = 1'b0;
        in_cont3   = 1'b0;
        next_fin3  = 1'b1;
        base_addr  = '0;
        skip_en    = 1'b0;
        skip_color = '0;

        // Reset values
        repeat (2) @(posedge Clck);
        #1;
        check("rst_plot", plot, 0);
        check("rst_busy", busy, 0);
        check("rst_out_cont", oc, 0);
        check("rst_x", xc, 0);
        check("rst_y", yc, 0);
        check("rst_colour", col, 0);
        check("rst_read_addr", ra, 0);
        check("rst_state", st, 0);
        Reset = 1'b1;
        @(posedge Clck); #1;
        check("idle_busy", busy, 0);

        // Plain frame, then a 20-cycle held handshake
        run_frame(14'h0000, 1'b0, 3'd0);
        finish_frame(20);

        // Address wrap from the top of the framebuffer
        run_frame(14'h3FFE, 1'b0, 3'd0);
        finish_frame(0);

        // Transparency on colour 3
        run_frame(14'h0000, 1'b1, 3'd3);
        finish_frame(2);

        // Reset while pixel (2,1) is being plotted
        base_addr = '0;
        skip_en   = 1'b0;
        in_cont   = 1'b1;
        @(posedge Clck); #1;
        in_cont = 1'b0;
        repeat (26) @(posedge Clck);
        #1;
        check("pre_rst_plot", plot, 1);
        check("pre_rst_x", xc, 2);
        check("pre_rst_y", yc, 1);
        Reset = 1'b0;
        #1;
        check("mid_rst_plot", plot, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_x", xc, 0);
        check("mid_rst_y", yc, 0);
        check("mid_rst_colour", col, 0);
        check("mid_rst_read_addr", ra, 0);
        repeat (2) @(posedge Clck);
        #1;
        Reset = 1'b1;
        plots = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge Clck); #1;
            if (plot || busy) plots++;
        end
        check("post_rst_quiet", plots, 0);
        run_frame(14'h0000, 1'b0, 3'd0);
        finish_frame(0);

        // Latency-3 instance: 6-cycle pitch, first four pixels
        base_addr = '0;
        skip_en   = 1'b0;
        in_cont3  = 1'b1;
        @(posedge Clck); #1;
        in_cont3 = 1'b0;
        for (int k = 1; k <= 24; k++) begin
            @(posedge Clck); #1;
            check("lat3_plot", plot3, k % 6 == 4);
            if (k % 6 == 4) begin
                check("lat3_colour", col3, ((k - 4) / 6) % 8);
                check("lat3_x", xc3, (k - 4) / 6);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/screen_blit.md
SCREEN_BLIT -- requirements
Module: screen_blit

Interface
REQ-001 Parameter SCR_W, default 112, pixels per row.
REQ-002 Parameter SCR_H, default 112, rows per frame.
REQ-003 Parameter X_BITS, default 7, x coordinate width; Y_BITS, default 7, y coordinate width.
REQ-004 Parameter COLOR_BITS, default 3, pixel colour width.
REQ-005 Parameter ADDR_BITS, default 14, framebuffer address width.
REQ-006 Parameter MEM_LATENCY, default 1 (legal 1..4), cycles from read_addr to valid read_data.
REQ-007 Clck  in  1  sole clock, all state on rising edge.
REQ-008 Reset  in  1  asynchronous, active-low reset.
REQ-009 in_cont_signal  in  1  start request (continuation in).
REQ-010 next_fin_signal  in  1  downstream continuation finished; releases out_cont_signal.
REQ-011 base_addr  in  ADDR_BITS  framebuffer start address, sampled at start.
REQ-012 skip_en  in  1  transparency enable, sampled at start.
REQ-013 skip_color  in  COLOR_BITS  transparent colour, sampled at start.
REQ-014 read_addr  out  ADDR_BITS  memory read address.
REQ-015 read_data  in  COLOR_BITS  memory read data.
REQ-016 x_co  out  X_BITS; y_co  out  Y_BITS  plot coordinates.
REQ-017 colour  out  COLOR_BITS  plot colour.
REQ-018 plot  out  1  one-cycle write strobe to the VGA adapter.
REQ-019 busy  out  1  high in every state except IDLE.
REQ-020 out_cont_signal  out  1  frame complete (continuation out).

Function
REQ-021 States: IDLE, ISSUE, WAIT, PLOT, ADVANCE, DONE; all outputs registered.
REQ-022 IDLE: in_cont_signal=1 -> latch base_addr/skip_en/skip_color, x_co=0, y_co=0, go ISSUE; else stay.
REQ-023 ISSUE: read_addr = base_latched + x_co + y_co*SCR_W, truncated modulo 2^ADDR_BITS; go WAIT with latency counter = MEM_LATENCY-1.
REQ-024 WAIT: decrement counter; at 0 capture read_data into colour, go PLOT.
REQ-025 PLOT: plot=1 for exactly this cycle unless skip_latched=1 and colour==skip_color_latched (plot stays 0); go ADVANCE.
REQ-026 ADVANCE: plot=0; if x_co==SCR_W-1 and y_co==SCR_H-1 go DONE; elif x_co==SCR_W-1 then x_co=0, y_co+1, go ISSUE; else x_co+1, go ISSUE.
REQ-027 Per-pixel cost MEM_LATENCY+3 cycles; frame cost SCR_W*SCR_H*(MEM_LATENCY+3) cycles from leaving IDLE to entering DONE.
REQ-028 DONE: out_cont_signal=1, held until next_fin_signal=1 sampled; then out_cont_signal=0 next cycle and go IDLE.
REQ-029 in_cont_signal outside IDLE is ignored; in_cont_signal still high on return to IDLE starts a new frame.
REQ-030 next_fin_signal outside DONE is ignored.
REQ-031 Latched inputs are stable for the whole frame; base_addr/skip changes mid-frame have no effect.
REQ-032 x_co/y_co never exceed SCR_W-1/SCR_H-1.

Reset
REQ-033 Reset=0 asynchronously forces IDLE, plot=0, out_cont_signal=0, busy=0, x_co=0, y_co=0, colour=0, read_addr=0, latched inputs=0.
REQ-034 Reset mid-frame abandons the frame with no further plot strobes; a new frame requires in_cont_signal after release.

Structure
REQ-035 Shared package screen_pkg holds the state enumeration, default SCR_W/SCR_H/COLOR_BITS/ADDR_BITS constants and the coordinate-to-offset function.
REQ-036 Sub-module pixel_scan_counter (x/y raster counter with row wrap and last-pixel flag) is instantiated once.

Verification
REQ-037 SCR_W=4, SCR_H=3, MEM_LATENCY=1, base=0, memory[i]=i mod 8, start pulse -> 12 plot strobes, colours 0..7,0..3 in raster order, out_cont_signal high at cycle 48 after start.
REQ-038 Same, base=0x3FFE, ADDR_BITS=14 -> read_addr sequence 0x3FFE, 0x3FFF, 0x0000, ...
REQ-039 skip_en=1, skip_color=3 -> exactly the pixels with colour 3 produce no plot strobe, coordinate sequence and timing unchanged.
REQ-040 out_cont_signal high, next_fin_signal held 0 for 20 cycles then pulsed -> out_cont_signal stays high 20 cycles, clears one cycle after pulse, busy falls.
REQ-041 Reset asserted at pixel (2,1) -> all outputs 0 immediately, no plot afterwards; restart renders full frame from (0,0).
REQ-042 MEM_LATENCY=3 -> 6-cycle pixel pitch, colour equals memory word issued 3 cycles earlier.
